// File: rtl/biriscv_csr_hpm_pkg.sv
// CSR address map and mhpmevent field positions shared by the HPM counter bank.
package biriscv_csr_hpm_pkg;

    localparam logic [11:0] CSR_MCYCLE        = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET      = 12'hB02;
    localparam logic [11:0] CSR_MHPMCOUNTER3  = 12'hB03;
    localparam logic [11:0] CSR_MCYCLEH       = 12'hB80;
    localparam logic [11:0] CSR_MINSTRETH     = 12'hB82;
    localparam logic [11:0] CSR_MHPMCOUNTER3H = 12'hB83;
    localparam logic [11:0] CSR_CYCLE         = 12'hC00;
    localparam logic [11:0] CSR_CYCLEH        = 12'hC80;
    localparam logic [11:0] CSR_MCOUNTINHIBIT = 12'h320;
    localparam logic [11:0] CSR_MHPMEVENT3    = 12'h323;
    localparam logic [11:0] CSR_MCOUNTEREN    = 12'h306;

    localparam int unsigned MHPMEVENT_OF   = 31;
    localparam int unsigned MHPMEVENT_MASK = 30;

    // Counter slot 0 is mcycle, slot 1 minstret, slots 2.. map to mhpmcounter3..
    function automatic logic [4:0] slot_idx(input int unsigned slot);
        if (slot == 0) return 5'd0;
        if (slot == 1) return 5'd2;
        return 5'(slot + 1);
    endfunction

    function automatic logic [31:0] cnt_mask(input int unsigned num_hpm);
        logic [31:0] m;
        m = 32'h0000_0005;
        for (int unsigned i = 3; i < 3 + num_hpm; i++) m[i] = 1'b1;
        return m;
    endfunction

endpackage

// File: rtl/biriscv_csr_hpm_if.sv
// CSR read (issue) and write (writeback) port into the HPM counter bank.
interface biriscv_csr_hpm_if;

    logic        csr_ren_i;
    logic [11:0] csr_raddr_i;
    logic [31:0] csr_rdata_o;
    logic        csr_hit_o;
    logic        csr_fault_o;
    logic [11:0] csr_waddr_i;
    logic [31:0] csr_wdata_i;

    modport master (
        output csr_ren_i, csr_raddr_i, csr_waddr_i, csr_wdata_i,
        input  csr_rdata_o, csr_hit_o, csr_fault_o
    );

    modport slave (
        input  csr_ren_i, csr_raddr_i, csr_waddr_i, csr_wdata_i,
        output csr_rdata_o, csr_hit_o, csr_fault_o
    );

endinterface

// File: rtl/biriscv_hpm_counter.sv
// Single wrapping counter with split lo/hi software writes and a carry-out pulse.
module biriscv_hpm_counter #(
    parameter int unsigned COUNTER_W = 48,
    parameter int unsigned INC_W     = 2
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [INC_W-1:0]     i_inc,
    input  logic                 i_inhibit,
    input  logic                 i_wr_lo,
    input  logic                 i_wr_hi,
    input  logic [31:0]          i_wdata,
    output logic [COUNTER_W-1:0] o_value,
    output logic                 o_carry
);

    logic [COUNTER_W-1:0] r_value;
    logic [COUNTER_W:0]   w_sum;

    assign w_sum   = {1'b0, r_value} + {{(COUNTER_W + 1 - INC_W){1'b0}}, i_inc};
    // A software write discards this cycle's increment, so it cannot carry either.
    assign o_carry = w_sum[COUNTER_W] & ~i_inhibit & ~i_wr_lo & ~i_wr_hi;
    assign o_value = r_value;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_value <= '0;
        end else if (i_wr_lo) begin
            r_value <= {r_value[COUNTER_W-1:32], i_wdata};
        end else if (i_wr_hi) begin
            r_value <= {i_wdata[COUNTER_W-33:0], r_value[31:0]};
        end else if (!i_inhibit) begin
            r_value <= w_sum[COUNTER_W-1:0];
        end
    end

endmodule

// File: rtl/biriscv_csr_hpm.sv
// Performance-counter CSR bank: mcycle, minstret, programmable mhpmcounters with
// event select, inhibit, user access control, sticky overflow and overflow interrupt.
module biriscv_csr_hpm #(
    parameter int unsigned NUM_HPM     = 4,
    parameter int unsigned COUNTER_W   = 48,
    parameter int unsigned NUM_EVENTS  = 8,
    parameter int unsigned EVENT_INC_W = 2
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic [1:0]                        instret_inc_i,
    input  logic [NUM_EVENTS*EVENT_INC_W-1:0] event_i,
    input  logic [1:0]                        priv_i,
    biriscv_csr_hpm_if.slave                  csr_bus,
    output logic                              ovf_irq_o
);

    import biriscv_csr_hpm_pkg::*;

    localparam int unsigned NumCnt  = NUM_HPM + 2;
    localparam int unsigned IncW    = (EVENT_INC_W > 2) ? EVENT_INC_W : 2;
    localparam logic [31:0] CntMask = cnt_mask(NUM_HPM);

    logic [COUNTER_W-1:0]   w_cnt [NumCnt];
    logic [NumCnt-1:0]      w_carry;
    logic [1:0]             w_unused_carry;
    logic [EVENT_INC_W-1:0] w_lane [NUM_EVENTS];
    logic [EVENT_INC_W-1:0] w_hpm_inc [NUM_HPM];

    logic [31:0]            r_inhibit;
    logic [31:0]            r_counteren;
    logic [7:0]             r_sel [NUM_HPM];
    logic [NUM_HPM-1:0]     r_of;
    logic [NUM_HPM-1:0]     r_mask;
    logic                   r_irq;

    logic [31:0]            w_rdata;
    logic                   w_hit;
    logic                   w_alias;
    logic [4:0]             w_idx;
    logic [63:0]            w_val;

    // mcycle and minstret wrap silently.
    assign w_unused_carry = w_carry[1:0];

    for (genvar k = 0; k < NUM_EVENTS; k++) begin : g_lane
        assign w_lane[k] = event_i[k*EVENT_INC_W +: EVENT_INC_W];
    end

    always_comb begin
        for (int i = 0; i < NUM_HPM; i++) begin
            w_hpm_inc[i] = '0;
            for (int k = 0; k < NUM_EVENTS; k++) begin
                if (r_sel[i] == 8'(k + 1)) w_hpm_inc[i] = w_lane[k];
            end
        end
    end

    for (genvar j = 0; j < NumCnt; j++) begin : g_cnt
        localparam logic [4:0] Idx = slot_idx(j);
        logic [IncW-1:0] w_inc;
        logic            w_wr_lo;
        logic            w_wr_hi;

        if (j == 0) begin : g_cycle
            assign w_inc = IncW'(1);
        end else if (j == 1) begin : g_instret
            assign w_inc = IncW'(instret_inc_i);
        end else begin : g_hpm
            assign w_inc = IncW'(w_hpm_inc[j-2]);
        end

        assign w_wr_lo = csr_bus.csr_waddr_i == (CSR_MCYCLE + 12'(Idx));
        assign w_wr_hi = csr_bus.csr_waddr_i == (CSR_MCYCLEH + 12'(Idx));

        biriscv_hpm_counter #(
            .COUNTER_W(COUNTER_W),
            .INC_W    (IncW)
        ) u_cnt (
            .i_clk    (clk_i),
            .i_rst    (rst_i),
            .i_inc    (w_inc),
            .i_inhibit(r_inhibit[Idx]),
            .i_wr_lo  (w_wr_lo),
            .i_wr_hi  (w_wr_hi),
            .i_wdata  (csr_bus.csr_wdata_i),
            .o_value  (w_cnt[j]),
            .o_carry  (w_carry[j])
        );
    end

    always_comb begin
        w_rdata = '0;
        w_hit   = 1'b0;
        w_alias = 1'b0;
        w_val   = '0;
        w_idx   = csr_bus.csr_raddr_i[4:0];
        if ((csr_bus.csr_raddr_i[11:8] == 4'hB || csr_bus.csr_raddr_i[11:8] == 4'hC) &&
            csr_bus.csr_raddr_i[6:5] == 2'b00 && w_idx != 5'd1) begin
            w_hit   = 1'b1;
            w_alias = csr_bus.csr_raddr_i[11:8] == 4'hC;
            for (int j = 0; j < NumCnt; j++) begin
                if (slot_idx(j) == w_idx) w_val = 64'(w_cnt[j]);
            end
            w_rdata = csr_bus.csr_raddr_i[7] ? w_val[63:32] : w_val[31:0];
        end else if (csr_bus.csr_raddr_i == CSR_MCOUNTINHIBIT) begin
            w_hit   = 1'b1;
            w_rdata = r_inhibit;
        end else if (csr_bus.csr_raddr_i == CSR_MCOUNTEREN) begin
            w_hit   = 1'b1;
            w_rdata = r_counteren;
        end else if (csr_bus.csr_raddr_i[11:5] == CSR_MHPMEVENT3[11:5] && w_idx >= 5'd3) begin
            w_hit = 1'b1;
            for (int i = 0; i < NUM_HPM; i++) begin
                if (w_idx == slot_idx(i + 2)) w_rdata = {r_of[i], r_mask[i], 22'b0, r_sel[i]};
            end
        end
        if (!csr_bus.csr_ren_i) w_rdata = '0;
    end

    assign csr_bus.csr_rdata_o = w_rdata;
    assign csr_bus.csr_hit_o   = w_hit;
    assign csr_bus.csr_fault_o = csr_bus.csr_ren_i & w_alias & (priv_i != 2'd3) &
                                 ~r_counteren[w_idx];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_inhibit   <= '0;
            r_counteren <= '0;
            r_of        <= '0;
            r_mask      <= '0;
            r_irq       <= 1'b0;
            for (int i = 0; i < NUM_HPM; i++) r_sel[i] <= '0;
        end else begin
            if (csr_bus.csr_waddr_i == CSR_MCOUNTINHIBIT) begin
                r_inhibit <= csr_bus.csr_wdata_i & CntMask;
            end
            if (csr_bus.csr_waddr_i == CSR_MCOUNTEREN) begin
                r_counteren <= csr_bus.csr_wdata_i & CntMask;
            end
            // A hardware overflow in the same cycle beats a software clear of OF.
            for (int i = 0; i < NUM_HPM; i++) begin
                if (csr_bus.csr_waddr_i == CSR_MHPMEVENT3 + 12'(i)) begin
                    r_sel[i]  <= csr_bus.csr_wdata_i[7:0];
                    r_mask[i] <= csr_bus.csr_wdata_i[MHPMEVENT_MASK];
                    r_of[i]   <= csr_bus.csr_wdata_i[MHPMEVENT_OF] | w_carry[i+2];
                end else if (w_carry[i+2]) begin
                    r_of[i] <= 1'b1;
                end
            end
            r_irq <= |(r_of & ~r_mask);
        end
    end

    assign ovf_irq_o = r_irq;

endmodule

// File: tb/tb_biriscv_csr_hpm.sv
// Self-checking bench for biriscv_csr_hpm: decode table plus multi-cycle counter sequences.
module tb_biriscv_csr_hpm;

    import biriscv_csr_hpm_pkg::*;

    localparam int unsigned NUM_HPM     = 4;
    localparam int unsigned COUNTER_W   = 48;
    localparam int unsigned NUM_EVENTS  = 8;
    localparam int unsigned EVENT_INC_W = 2;

    logic        clk;
    logic        rst;
    logic [1:0]  instret_inc;
    logic [15:0] ev;
    logic [1:0]  priv;
    logic        ovf_irq;

    biriscv_csr_hpm_if u_if ();

    biriscv_csr_hpm #(
        .NUM_HPM    (NUM_HPM),
        .COUNTER_W  (COUNTER_W),
        .NUM_EVENTS (NUM_EVENTS),
        .EVENT_INC_W(EVENT_INC_W)
    ) u_dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .instret_inc_i(instret_inc),
        .event_i      (ev),
        .priv_i       (priv),
        .csr_bus      (u_if),
        .ovf_irq_o    (ovf_irq)
    );

    typedef struct {
        string       name;
        logic [31:0] rdata;
        logic        hit;
        logic        fault;
    } exp_t;

    typedef struct {
        string       name;
        logic [11:0] addr;
        logic [1:0]  priv;
        logic        ren;
        logic [31:0] rdata;
        logic        hit;
        logic        fault;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[$];
    int   n_cmp;
    int   n_err;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mkv(input string n, input logic [11:0] a, input logic [1:0] p,
                                 input logic r, input logic h, input logic f);
        vec_t v;
        v.name = n; v.addr = a; v.priv = p; v.ren = r; v.rdata = 32'h0; v.hit = h; v.fault = f;
        return v;
    endfunction

    task automatic cycle(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d);
        u_if.csr_waddr_i = a;
        u_if.csr_wdata_i = d;
        cycle();
        u_if.csr_waddr_i = 12'h000;
    endtask

    task automatic check_out();
        exp_t e;
        e = sb.pop_front();
        n_cmp++;
        if (u_if.csr_rdata_o !== e.rdata || u_if.csr_hit_o !== e.hit ||
            u_if.csr_fault_o !== e.fault) begin
            n_err++;
            $display("FAIL %s: got rdata=%h hit=%b fault=%b, want rdata=%h hit=%b fault=%b",
                     e.name, u_if.csr_rdata_o, u_if.csr_hit_o, u_if.csr_fault_o,
                     e.rdata, e.hit, e.fault);
        end
    endtask

    task automatic rd(input string n, input logic [11:0] a, input logic [1:0] p, input logic r,
                      input logic [31:0] d, input logic h, input logic f);
        exp_t e;
        u_if.csr_ren_i   = r;
        u_if.csr_raddr_i = a;
        priv             = p;
        e.name = n; e.rdata = d; e.hit = h; e.fault = f;
        sb.push_back(e);
        #1;
        check_out();
    endtask

    task automatic rdm(input string n, input logic [11:0] a, input logic [31:0] d);
        rd(n, a, 2'd3, 1'b1, d, 1'b1, 1'b0);
    endtask

    task automatic chk_irq(input string n, input logic exp);
        n_cmp++;
        if (ovf_irq !== exp) begin
            n_err++;
            $display("FAIL %s: got ovf_irq=%b, want %b", n, ovf_irq, exp);
        end
    endtask

    initial begin
        n_cmp            = 0;
        n_err            = 0;
        rst              = 1'b1;
        instret_inc      = 2'd0;
        ev               = 16'h0;
        priv             = 2'd3;
        u_if.csr_ren_i   = 1'b0;
        u_if.csr_raddr_i = 12'h0;
        u_if.csr_waddr_i = 12'h0;
        u_if.csr_wdata_i = 32'h0;

        // Decode table, applied while held in reset (all state zero).
        vecs.push_back(mkv("rst_mcycle",      12'hB00, 2'd3, 1'b1, 1'b1, 1'b0));
        vecs.push_back(mkv("time_lo_nohit",   12'hB01, 2'd3, 1'b1, 1'b0, 1'b0));
        vecs.push_back(mkv("rst_minstret",    12'hB02, 2'd3, 1'b1, 1'b1, 1'b0));
        vecs.push_back(mkv("rst_mcycleh",     12'hB80, 2'd3, 1'b1, 1'b1, 1'b0));
        vecs.push_back(mkv("time_hi_nohit",   12'hB81, 2'd3, 1'b1, 1'b0, 1'b0));
        vecs.push_back(mkv("rst_hpm6",        12'hB06, 2'd3, 1'b1, 1'b1, 1'b0));
        vecs.push_back(mkv("unimpl_hpm31",    12'hB1F, 2'd3, 1'b1, 1'b1, 1'b0));
        vecs.push_back(mkv("b20_nohit",       12'hB20, 2'd3, 1'b1, 1'b0, 1'b0));
        vecs.push_back(mkv("alias_u_fault",   12'hC03, 2'd0, 1'b1, 1'b1, 1'b1));
        vecs.push_back(mkv("alias_m_ok",      12'hC03, 2'd3, 1'b1, 1'b1, 1'b0));
        vecs.push_back(mkv("alias_hi_s_flt",  12'hC83, 2'd1, 1'b1, 1'b1, 1'b1));
        vecs.push_back(mkv("rst_inhibit",     12'h320, 2'd3, 1'b1, 1'b1, 1'b0));
        vecs.push_back(mkv("321_nohit",       12'h321, 2'd3, 1'b1, 1'b0, 1'b0));
        vecs.push_back(mkv("rst_counteren",   12'h306, 2'd3, 1'b1, 1'b1, 1'b0));
        vecs.push_back(mkv("unimpl_event31",  12'h33F, 2'd3, 1'b1, 1'b1, 1'b0));
        vecs.push_back(mkv("340_nohit",       12'h340, 2'd3, 1'b1, 1'b0, 1'b0));
        vecs.push_back(mkv("alias_noren",     12'hC03, 2'd0, 1'b0, 1'b1, 1'b0));

        #1;
        foreach (vecs[i]) begin
            rd(vecs[i].name, vecs[i].addr, vecs[i].priv, vecs[i].ren, vecs[i].rdata,
               vecs[i].hit, vecs[i].fault);
        end
        chk_irq("irq_reset", 1'b0);

        @(negedge clk);
        rst = 1'b0;

        // Idle counting.
        cycle(10);
        rdm("mcycle_10", CSR_MCYCLE, 32'd10);
        rdm("mcycleh_0", CSR_MCYCLEH, 32'd0);
        rdm("minstret_0", CSR_MINSTRET, 32'd0);
        chk_irq("irq_idle", 1'b0);

        // minstret and inhibit timing.
        instret_inc = 2'd2;
        cycle(5);
        instret_inc = 2'd1;
        cycle(3);
        instret_inc = 2'd0;
        rdm("minstret_13", CSR_MINSTRET, 32'd13);
        wr(CSR_MCOUNTINHIBIT, 32'h4);
        instret_inc = 2'd2;
        cycle(4);
        instret_inc = 2'd0;
        rdm("minstret_inhib", CSR_MINSTRET, 32'd13);
        rdm("inhibit_4", CSR_MCOUNTINHIBIT, 32'h4);
        wr(CSR_MCOUNTINHIBIT, 32'hFFFF_FFFF);
        rdm("inhibit_mask", CSR_MCOUNTINHIBIT, 32'h0000_007D);
        instret_inc = 2'd2;
        wr(CSR_MCOUNTINHIBIT, 32'h0);
        rdm("inhibit_wr_cycle", CSR_MINSTRET, 32'd13);
        cycle();
        instret_inc = 2'd0;
        rdm("minstret_15", CSR_MINSTRET, 32'd15);
        rdm("minstreth_0", CSR_MINSTRETH, 32'd0);

        // Event selection.
        wr(CSR_MHPMEVENT3, 32'd3);
        for (int i = 0; i < 4; i++) begin
            ev      = 16'h0030;
            ev[1:0] = 2'(i + 1);
            cycle();
        end
        ev = 16'h0;
        rdm("hpm3_12", CSR_MHPMCOUNTER3, 32'd12);
        rdm("hpm3h_0", CSR_MHPMCOUNTER3H, 32'd0);
        wr(CSR_MHPMEVENT3, 32'd9);
        ev = 16'hFFFF;
        cycle(3);
        ev = 16'h0;
        rdm("hpm3_sel9_frozen", CSR_MHPMCOUNTER3, 32'd12);
        rdm("event3_9", CSR_MHPMEVENT3, 32'd9);
        rdm("hpm4_sel0", CSR_MHPMCOUNTER3 + 12'd1, 32'd0);
        wr(CSR_MHPMEVENT3, 32'd8);
        ev = 16'hC000;
        cycle(2);
        ev = 16'h0;
        rdm("hpm3_sel8", CSR_MHPMCOUNTER3, 32'd18);

        // Overflow, irq and mask.
        wr(CSR_MHPMEVENT3, 32'd3);
        wr(CSR_MHPMCOUNTER3H, 32'h0000_FFFF);
        wr(CSR_MHPMCOUNTER3, 32'hFFFF_FFFE);
        rdm("pre_ovf_lo", CSR_MHPMCOUNTER3, 32'hFFFF_FFFE);
        rdm("pre_ovf_hi", CSR_MHPMCOUNTER3H, 32'h0000_FFFF);
        rdm("pre_ovf_event", CSR_MHPMEVENT3, 32'h0000_0003);
        ev = 16'h0030;
        cycle();
        ev = 16'h0;
        rdm("ovf_lo", CSR_MHPMCOUNTER3, 32'd1);
        rdm("ovf_hi", CSR_MHPMCOUNTER3H, 32'd0);
        rdm("ovf_of_set", CSR_MHPMEVENT3, 32'h8000_0003);
        chk_irq("irq_lag", 1'b0);
        cycle();
        chk_irq("irq_set", 1'b1);
        wr(CSR_MHPMEVENT3, 32'hC000_0003);
        chk_irq("irq_mask_lag", 1'b1);
        cycle();
        chk_irq("irq_masked", 1'b0);
        rdm("of_kept_masked", CSR_MHPMEVENT3, 32'hC000_0003);

        // Overflow and software clear of OF in the same cycle.
        wr(CSR_MHPMCOUNTER3H, 32'h0000_FFFF);
        wr(CSR_MHPMCOUNTER3, 32'hFFFF_FFFF);
        ev = 16'h0010;
        wr(CSR_MHPMEVENT3, 32'h0000_0003);
        ev = 16'h0;
        rdm("set_wins", CSR_MHPMEVENT3, 32'h8000_0003);
        rdm("wrap_zero", CSR_MHPMCOUNTER3, 32'd0);
        chk_irq("irq_sw_lag", 1'b0);
        cycle();
        chk_irq("irq_unmasked", 1'b1);
        wr(CSR_MHPMEVENT3, 32'h0000_0003);
        rdm("of_cleared", CSR_MHPMEVENT3, 32'h0000_0003);
        cycle();
        chk_irq("irq_cleared", 1'b0);

        // Write drops the same-cycle increment; hi write truncates.
        ev = 16'h0020;
        wr(CSR_MHPMCOUNTER3, 32'h0000_0100);
        rdm("wr_drops_inc", CSR_MHPMCOUNTER3, 32'h0000_0100);
        cycle();
        ev = 16'h0;
        rdm("inc_after_wr", CSR_MHPMCOUNTER3, 32'h0000_0102);
        wr(CSR_MHPMCOUNTER3H, 32'hABCD_1234);
        rdm("hi_trunc", CSR_MHPMCOUNTER3H, 32'h0000_1234);
        rdm("lo_kept", CSR_MHPMCOUNTER3, 32'h0000_0102);

        // User aliases and mcounteren.
        rd("alias_fault", 12'hC03, 2'd0, 1'b1, 32'h0000_0102, 1'b1, 1'b1);
        wr(12'hC03, 32'h0000_0055);
        rdm("alias_wr_ignored", CSR_MHPMCOUNTER3, 32'h0000_0102);
        wr(CSR_MCOUNTEREN, 32'h0000_0008);
        rdm("counteren_8", CSR_MCOUNTEREN, 32'h0000_0008);
        rd("alias_allowed", 12'hC03, 2'd0, 1'b1, 32'h0000_0102, 1'b1, 1'b0);
        rd("alias_hi_allowed", 12'hC83, 2'd1, 1'b1, 32'h0000_1234, 1'b1, 1'b0);
        rd("alias_instret_flt", 12'hC02, 2'd1, 1'b1, 32'd15, 1'b1, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/biriscv_csr_hpm.md
Name: biriscv_csr_hpm

Overview:
Parametrised performance-counter CSR bank for the dual-issue core. It is the successor to the fixed mcycle/minstret handling in the CSR unit and owns mcycle, minstret, NUM_HPM programmable mhpmcounterN, mhpmeventN, mcountinhibit and mcounteren. It sits beside the CSR register file: reads happen at issue, writes arrive from writeback. It adds per-counter event selection, inhibit, user-mode access control, sticky overflow and an overflow interrupt.

Parameters:
NUM_HPM, 4, number of programmable counters (1..29), mapped to mhpmcounter3..(3+NUM_HPM-1)
COUNTER_W, 48, counter width in bits (33..64)
NUM_EVENTS, 8, number of event input lanes
EVENT_INC_W, 2, per-lane increment width; supports up to 3 events/cycle

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous reset, active-high
instret_inc_i  in  2  instructions retired this cycle (0..2)
event_i  in  NUM_EVENTS*EVENT_INC_W  per-lane event count this cycle; lane k is bits [k*EVENT_INC_W +: EVENT_INC_W]
priv_i  in  2  current privilege (0=U, 1=S, 3=M)
csr_ren_i  in  1  read enable at issue
csr_raddr_i  in  12  read address
csr_rdata_o  out  32  read data (combinational)
csr_hit_o  out  1  address belongs to this block (combinational)
csr_fault_o  out  1  user/supervisor access denied by mcounteren (combinational)
csr_waddr_i  in  12  write address; 0 = no write
csr_wdata_i  in  32  write data
ovf_irq_o  out  1  registered OR of unmasked overflow flags

Behaviour:
- Reset (async, rst_i=1): all counters 0, mhpmevent 0, mcountinhibit 0, mcounteren 0, ovf_irq_o 0.
- Address map: mcycle 0xB00/0xB80 (lo/hi); minstret 0xB02/0xB82; mhpmcounterN 0xB00+N / 0xB80+N; user aliases 0xC00+N / 0xC80+N (read-only); mhpmeventN 0x320+N; mcountinhibit 0x320; mcounteren 0x306. Counter index 1 (time) is not implemented: no hit.
- Read: rdata = 0 when !csr_ren_i or no hit. Hi half returns counter[COUNTER_W-1:32] zero-extended. Unimplemented HPM indices inside the range read 0 with hit=1.
- csr_fault_o = csr_ren_i & alias address (0xC**) & priv_i != 3 & !mcounteren[idx]. Writes to 0xC** are ignored here; the issue stage raises the illegal-instruction exception.
- Increment, per edge when the inhibit bit is clear:
  - mcycle += 1.
  - minstret += instret_inc_i.
  - mhpmcounterN += event_i lane (sel-1), where sel = mhpmeventN[7:0]. sel=0 or sel>NUM_EVENTS means no increment.
  - Arithmetic is modulo 2^COUNTER_W.
- Write: takes effect on the next edge. Lo write replaces bits [31:0] and keeps the hi bits. Hi write replaces bits [COUNTER_W-1:32]; excess wdata bits are dropped. The increment in the write cycle is discarded for that counter only.
- mcountinhibit/mcounteren: only bits 0, 2 and 3..(2+NUM_HPM) are writable; the others read 0. A new inhibit value applies from the cycle after the write.
- mhpmeventN: bits [7:0] hold the selector. Bit 31 is the sticky OF flag. Bit 30 is OF mask (1 = no irq). Other bits read 0.
- Overflow: when an HPM increment carries out of bit COUNTER_W-1, the counter wraps and OF is set.
  - OF is cleared only by a software write of 0 to bit 31.
  - If an overflow and a software clear land in the same cycle, the set wins.
  - mcycle and minstret wrap silently.
- ovf_irq_o = registered |(OF & ~mask); it asserts 1 cycle after OF is set.

Decomposition:
- Shared package: CSR address constants (CSR_MCYCLE, CSR_MINSTRET, CSR_MHPMCOUNTER3, CSR_MHPMEVENT3, CSR_MCOUNTINHIBIT, CSR_MCOUNTEREN, CSR_CYCLE, *_H offsets) and the MHPMEVENT_OF/MASK bit indices.
- Sub-module biriscv_hpm_counter (params COUNTER_W, INC_W):
  - inputs: inc, inhibit, wr_lo, wr_hi, wdata
  - outputs: value, carry pulse
  - instantiated NUM_HPM+2 times.

Test Plan:
- Reset, then 10 idle cycles, no inhibit -> mcycle lo reads 10, minstret 0, ovf_irq_o 0.
- instret_inc_i=2 for 5 cycles, then 1 for 3 cycles -> minstret reads 13. Set mcountinhibit bit 2; 4 more cycles of 2 -> still 13.
- mhpmevent3=3, event lane 2=3 for 4 cycles; lane 0 toggling -> mhpmcounter3=12. Set sel=9 (out of range) -> counter frozen.
- Write hi 0xFFFF and lo 0xFFFFFFFE (COUNTER_W=48), event +3 -> counter=1, OF set, ovf_irq_o high the next cycle. Write mask=1 -> irq drops; OF still reads 1.
- Write mhpmcounter3 lo=0x100 in a cycle with event +2 -> reads 0x100 (increment dropped). Next cycle +2 -> 0x102.
- priv_i=0, read 0xC03 with mcounteren=0 -> fault=1. Set mcounteren bit 3 -> fault=0, rdata equals the mhpmcounter3 lo value.
